instr_fetch_queue: RTL and testbench

Parametrised instruction fetch unit with a prefetch queue, sitting between the instruction memory and the decode stage. It owns the fetch PC and issues one word-addressed read per cycle to a synchronous instruction memory with 1-cycle read latency. Returned words are buffered with their PCs in a DEPTH-entry FIFO and handed to decode over a valid/ready handshake. A branch/jump redirect flushes the queue, discards any in-flight read and restarts fetch at a new PC.

---
 rtl/instr_fetch_queue.sv | 93 +++++++++
 tb/tb_instr_fetch_queue.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Instruction fetch unit: owns the fetch PC, issues one read per cycle to a
// 1-cycle-latency instruction memory and buffers returned words in a prefetch FIFO.
module instr_fetch_queue #(
    parameter int unsigned       XLEN     = 32,
    parameter int unsigned       ADDR_W   = 8,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     imem_req,
    output logic [ADDR_W-1:0]        imem_addr,
    input  logic [XLEN-1:0]          imem_rdata,
    input  logic                     redirect_valid,
    input  logic [ADDR_W-1:0]        redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_instr,
    output logic [ADDR_W-1:0]        out_pc,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    logic [ADDR_W-1:0] fpc;
    logic              inflight;
    logic [ADDR_W-1:0] ipc;
    logic [XLEN-1:0]   instr_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem    [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW:0]       occupancy;
    logic              push;
    logic              pop;

    // Credit rule: queued entries plus the word in flight never exceed DEPTH,
    // so a returning word always has a free slot.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign imem_req  = !reset && !redirect_valid && (occupancy < DEPTH_C);
    assign imem_addr = fpc;

    assign out_valid = (count != '0) && !redirect_valid;
    assign out_instr = instr_mem[rd_ptr];
    assign out_pc    = pc_mem[rd_ptr];

    assign push = inflight && !redirect_valid;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            fpc      <= RESET_PC;
            inflight <= 1'b0;
            ipc      <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                instr_mem[i] <= '0;
                pc_mem[i]    <= '0;
            end
        end else if (redirect_valid) begin
            fpc      <= redirect_pc;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (imem_req) begin
                fpc      <= fpc + 1'b1;
                inflight <= 1'b1;
                ipc      <= fpc;
            end else begin
                inflight <= 1'b0;
            end

            if (push) begin
                instr_mem[wr_ptr] <= imem_rdata;
                pc_mem[wr_ptr]    <= ipc;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: directed phases push expected PCs,
// a negedge monitor pops and compares every accepted instruction.
module tb_instr_fetch_queue;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CW     = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, reset2;
    logic              redirect_valid, out_ready;
    logic [ADDR_W-1:0] redirect_pc;
    logic              imem_req, imem_req2;
    logic [ADDR_W-1:0] imem_addr, imem_addr2;
    logic [XLEN-1:0]   imem_rdata, imem_rdata2;
    logic              out_valid, out_valid2;
    logic [XLEN-1:0]   out_instr, out_instr2;
    logic [ADDR_W-1:0] out_pc, out_pc2;
    logic [CW-1:0]     count, count2;

    instr_fetch_queue #(.XLEN(XLEN), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(8'h00)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .count(count)
    );

    // Second instance free-runs from a PC near the top of the address space.
    instr_fetch_queue #(.XLEN(XLEN), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(8'hFE)) dut_wrap (
        .clk(clk), .reset(reset2), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_rdata(imem_rdata2), .redirect_valid(1'b0), .redirect_pc(8'h00),
        .out_valid(out_valid2), .out_ready(1'b1), .out_instr(out_instr2),
        .out_pc(out_pc2), .count(count2)
    );

    function automatic logic [XLEN-1:0] word_at(input logic [ADDR_W-1:0] a);
        return 32'h1000 + {24'h0, a};
    endfunction

    always @(posedge clk) begin
        if (imem_req)  imem_rdata  <= word_at(imem_addr);
        if (imem_req2) imem_rdata2 <= word_at(imem_addr2);
    end

    int vectors = 0;
    int miscompares = 0;
    logic [ADDR_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] exp2_q[$];
    logic [ADDR_W-1:0] e1, e2;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_pop: got pc 0x%0h, expected no output at %0t", out_pc, $time);
            end else begin
                e1 = exp_q.pop_front();
                check("pop_pc", 64'(out_pc), 64'(e1));
                check("pop_instr", 64'(out_instr), 64'(word_at(e1)));
            end
        end
        if (out_valid2 && exp2_q.size() != 0) begin
            e2 = exp2_q.pop_front();
            check("wrap_pc", 64'(out_pc2), 64'(e2));
            check("wrap_instr", 64'(out_instr2), 64'(word_at(e2)));
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; reset2 = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_req",   64'(imem_req),  64'd0);
        check("rst_addr",  64'(imem_addr), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_instr", 64'(out_instr), 64'd0);
        check("rst_pc",    64'(out_pc),    64'd0);
        check("rst_count", 64'(count),     64'd0);
        check("rst2_addr", 64'(imem_addr2), 64'hFE);
        check("rst2_count", 64'(count2),   64'd0);

        // Free-running stream from reset
        step();
        for (int i = 0; i < 8; i++) exp_q.push_back(ADDR_W'(i));
        exp2_q.push_back(8'hFE); exp2_q.push_back(8'hFF);
        exp2_q.push_back(8'h00); exp2_q.push_back(8'h01);
        reset = 1'b0; reset2 = 1'b0;
        @(negedge clk);
        check("c0_req",   64'(imem_req),  64'd1);
        check("c0_addr",  64'(imem_addr), 64'd0);
        check("c0_valid", 64'(out_valid), 64'd0);
        step(); @(negedge clk);
        check("c1_valid", 64'(out_valid), 64'd0);
        for (int i = 0; i < 8; i++) begin
            step(); @(negedge clk);
            check("stream_valid", 64'(out_valid), 64'd1);
        end
        step();
        reset = 1'b1; out_ready = 1'b0;

        // Back-pressure fill and release
        step();
        reset = 1'b0;
        repeat (9) step();
        @(negedge clk);
        check("fill_count", 64'(count),     64'd4);
        check("fill_req",   64'(imem_req),  64'd0);
        check("fill_valid", 64'(out_valid), 64'd1);
        check("fill_addr",  64'(imem_addr), 64'd4);
        step();
        for (int i = 0; i < 6; i++) exp_q.push_back(ADDR_W'(i));
        out_ready = 1'b1;
        @(negedge clk);
        check("rel0_req",   64'(imem_req),  64'd0);
        check("rel0_valid", 64'(out_valid), 64'd1);
        step(); @(negedge clk);
        check("rel1_req",   64'(imem_req),  64'd1);
        check("rel1_addr",  64'(imem_addr), 64'd4);
        check("rel1_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 4; i++) begin
            step(); @(negedge clk);
            check("rel_valid", 64'(out_valid), 64'd1);
        end
        step();
        out_ready = 1'b0; reset = 1'b1;

        // Redirect with a word in flight and two queued
        step();
        reset = 1'b0;
        repeat (3) step();
        redirect_valid = 1'b1; redirect_pc = 8'h40;
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h40 + ADDR_W'(i));
        @(negedge clk);
        check("rd_count", 64'(count),     64'd2);
        check("rd_valid", 64'(out_valid), 64'd0);
        check("rd_req",   64'(imem_req),  64'd0);
        step();
        redirect_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("rd1_count", 64'(count),     64'd0);
        check("rd1_valid", 64'(out_valid), 64'd0);
        check("rd1_req",   64'(imem_req),  64'd1);
        check("rd1_addr",  64'(imem_addr), 64'h40);
        step(); @(negedge clk);
        check("rd2_valid", 64'(out_valid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            step(); @(negedge clk);
            check("rd_stream_valid", 64'(out_valid), 64'd1);
        end

        // Redirect while decode is ready and the queue is non-empty
        step();
        redirect_valid = 1'b1; redirect_pc = 8'h80;
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h80 + ADDR_W'(i));
        @(negedge clk);
        check("rr_count", 64'(count),     64'd1);
        check("rr_valid", 64'(out_valid), 64'd0);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("rr1_count", 64'(count),     64'd0);
        check("rr1_addr",  64'(imem_addr), 64'h80);
        check("rr1_req",   64'(imem_req),  64'd1);
        step(); @(negedge clk);
        check("rr2_valid", 64'(out_valid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            step(); @(negedge clk);
            check("rr_stream_valid", 64'(out_valid), 64'd1);
        end
        step();
        out_ready = 1'b0; reset = 1'b1;

        // One-cycle reset mid-stream with three entries queued
        step();
        reset = 1'b0;
        repeat (4) step();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(ADDR_W'(i));
        @(negedge clk);
        check("mid_count", 64'(count),    64'd3);
        check("mid_req",   64'(imem_req), 64'd0);
        step();
        reset = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("mid1_count", 64'(count),     64'd0);
        check("mid1_valid", 64'(out_valid), 64'd0);
        check("mid1_req",   64'(imem_req),  64'd1);
        check("mid1_addr",  64'(imem_addr), 64'd0);
        step(); @(negedge clk);
        check("mid2_valid", 64'(out_valid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            step(); @(negedge clk);
            check("mid_stream_valid", 64'(out_valid), 64'd1);
        end
        step();
        out_ready = 1'b0;
        @(negedge clk);

        check("sb_drained",  64'(exp_q.size()),  64'd0);
        check("sb2_drained", 64'(exp2_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
